fpu_mult_arbiter: RTL and testbench

//  Shares one fpu_multiplier between NUM_REQ requesters (matrix-multiply lanes) with round-robin arbitration.

---
 rtl/fpu_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/fpu_mult_arbiter.sv | 135 +++++++++++++
 tb/tb_fpu_mult_arbiter.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types for the multiplier arbiter slice.
// Holds the arbiter FSM state encoding and the default FP width.
package fpu_pkg;

  localparam int FPBITS_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_Z,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set bit after ptr.
// Ports: req, ptr in; grant (onehot), grant_idx, any out.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  int idx;

  // Scan from the farthest offset down to ptr+1 so the
  // nearest requester after ptr is the last one written.
  always_comb begin
    idx       = 0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[ID_W'(idx)]) begin
        grant_idx = ID_W'(idx);
        any       = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/fpu_mult_arbiter.sv
// fpu_mult_arbiter: shares one fpu_multiplier among NUM_REQ lanes.
// Ports: req_* (valid/a/b/ready), resp_* (valid/z/ready),
//  input_a/b + stb/ack and output_z + stb/ack to the multiplier,
//  busy (not IDLE), grant_id (current/last grant).
module fpu_mult_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FPBITS  = FPBITS_DEFAULT,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][FPBITS-1:0] req_a,
  input  logic [NUM_REQ-1:0][FPBITS-1:0] req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [FPBITS-1:0]              resp_z,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [FPBITS-1:0]              input_a,
  output logic                           input_a_stb,
  input  logic                           input_a_ack,
  output logic [FPBITS-1:0]              input_b,
  output logic                           input_b_stb,
  input  logic                           input_b_ack,
  input  logic [FPBITS-1:0]              output_z,
  input  logic                           output_z_stb,
  output logic                           output_z_ack,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id
);

  arb_state_t state_q, state_d;

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    gid_q;
  logic [FPBITS-1:0]  a_q;
  logic [FPBITS-1:0]  b_q;
  logic [FPBITS-1:0]  z_q;
  logic               zack_q;

  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;

  logic               take;
  logic               z_hit;
  logic               done;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (pick_oh),
    .grant_idx(pick_id),
    .any      (pick_any)
  );

  assign take  = (state_q == IDLE) && pick_any;
  assign z_hit = (state_q == WAIT_Z) && output_z_stb;
  assign done  = (state_q == RESP) && resp_ready[gid_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    resp_valid  = '0;
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_oh;
          state_d   = SEND_A;
        end
      end
      SEND_A: begin
        input_a_stb = 1'b1;
        if (input_a_ack) state_d = SEND_B;
      end
      SEND_B: begin
        input_b_stb = 1'b1;
        if (input_b_ack) state_d = WAIT_Z;
      end
      WAIT_Z: begin
        if (output_z_stb) state_d = RESP;
      end
      RESP: begin
        resp_valid[gid_q] = 1'b1;
        if (resp_ready[gid_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer starts at the last index so lane 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= ID_W'(NUM_REQ - 1);
      gid_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      z_q    <= '0;
      zack_q <= 1'b0;
    end else begin
      zack_q <= 1'b0;
      if (take) begin
        a_q   <= req_a[pick_id];
        b_q   <= req_b[pick_id];
        gid_q <= pick_id;
      end
      // Ack is registered: one cycle, aligned with RESP entry.
      if (z_hit) begin
        z_q    <= output_z;
        zack_q <= 1'b1;
      end
      if (done) ptr_q <= gid_q;
    end
  end

  assign input_a      = a_q;
  assign input_b      = b_q;
  assign resp_z       = z_q;
  assign output_z_ack = zack_q;
  assign busy         = (state_q != IDLE);
  assign grant_id     = gid_q;

endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// tb_fpu_mult_arbiter: scoreboard bench with a multiplier stub.
// Directed scenarios followed by randomized multi-lane traffic.
module tb_fpu_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0][W-1:0] req_a;
  logic [N-1:0][W-1:0] req_b;
  logic [N-1:0]        req_ready;
  logic [N-1:0]        resp_valid;
  logic [W-1:0]        resp_z;
  logic [N-1:0]        resp_ready;
  logic [W-1:0]        input_a;
  logic                input_a_stb;
  logic                input_a_ack;
  logic [W-1:0]        input_b;
  logic                input_b_stb;
  logic                input_b_ack;
  logic [W-1:0]        output_z;
  logic                output_z_stb;
  logic                output_z_ack;
  logic                busy;
  logic [IW-1:0]       grant_id;

  always #5 clk = ~clk;

  fpu_mult_arbiter #(
    .NUM_REQ(N),
    .FPBITS (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_z      (resp_z),
    .resp_ready  (resp_ready),
    .input_a     (input_a),
    .input_a_stb (input_a_stb),
    .input_a_ack (input_a_ack),
    .input_b     (input_b),
    .input_b_stb (input_b_stb),
    .input_b_ack (input_b_ack),
    .output_z    (output_z),
    .output_z_stb(output_z_stb),
    .output_z_ack(output_z_ack),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
  } exp_t;

  exp_t   sb[$];
  int     glog[$];
  exp_t   me;
  int     tests = 0;
  int     fails = 0;
  int     done_cnt = 0;
  int     last_id = -1;
  logic [W-1:0] last_z = '0;
  int     ptr_m = N - 1;
  logic [N-1:0] gnt_seen = '0;
  logic [N-1:0] waiting = '0;
  int     b_len = 0;
  int     last_b_len = 0;
  int     a_dly_f = -1;
  int     b_dly_f = -1;
  int     z_dly_f = -1;
  logic   z_pending = 1'b0;
  int     mw;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Single-precision multiply for normal operands/results,
  // round to nearest even.
  function automatic logic [W-1:0] fmul(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [24:0] m;
    logic        g;
    logic        st;
    s = a[31] ^ b[31];
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    if (p[47]) begin
      e++;
      m  = {1'b0, p[47:24]};
      g  = p[23];
      st = |p[22:0];
    end else begin
      m  = {1'b0, p[46:23]};
      g  = p[22];
      st = |p[21:0];
    end
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = 25'h0800000;
      e++;
    end
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [W-1:0] rand_fp();
    logic [7:0] ex;
    ex = 8'($urandom_range(110, 144));
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  // Round-robin rule: first requester after p, wrapping.
  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_vs_inflight", 64'(busy), 64'(sb.size() != 0));
      if (req_ready != '0) begin
        chk("grant_onehot", 64'($onehot(req_ready)), 1);
        chk("grant_while_idle", 64'(busy), 0);
        mw = rr_pick(ptr_m, req_valid);
        chk("grant_rr", 64'(req_ready), (mw < 0) ? 0 : (64'd1 << mw));
        if (mw >= 0) begin
          me.id = mw;
          me.a  = req_a[mw];
          me.b  = req_b[mw];
          me.z  = fmul(req_a[mw], req_b[mw]);
          sb.push_back(me);
          glog.push_back(mw);
          gnt_seen[mw] = 1'b1;
          waiting[mw]  = 1'b1;
        end
      end
      if (input_a_stb || input_b_stb) begin
        if (sb.size() == 0) chk("stb_without_grant", 1, 0);
        else if (input_a_stb) chk("input_a", 64'(input_a), 64'(sb[0].a));
        else chk("input_b", 64'(input_b), 64'(sb[0].b));
      end
      if (input_b_stb) b_len++;
      else if (b_len != 0) begin
        last_b_len = b_len;
        b_len = 0;
      end
      if (output_z_ack) chk("z_ack_in_resp", 64'(resp_valid != '0), 1);
      if (resp_valid != '0) begin
        if (sb.size() == 0) chk("resp_unexpected", 64'(resp_valid), 0);
        else begin
          me = sb[0];
          chk("resp_valid_id", 64'(resp_valid), 64'd1 << me.id);
          chk("resp_z", 64'(resp_z), 64'(me.z));
          chk("grant_id", 64'(grant_id), 64'(me.id));
          if (resp_ready[me.id]) begin
            void'(sb.pop_front());
            ptr_m    = me.id;
            last_z   = resp_z;
            last_id  = me.id;
            waiting[me.id] = 1'b0;
            done_cnt++;
          end
        end
      end
    end
  end

  // Multiplier stub: configurable stb->ack and result delays.
  initial begin
    int a_cnt, b_cnt, z_cnt, a_d, b_d, z_d;
    logic [W-1:0] al;
    logic [W-1:0] zv;
    a_cnt = 0; b_cnt = 0; z_cnt = 0;
    a_d = 0; b_d = 0; z_d = 0;
    al = '0; zv = '0;
    input_a_ack = 1'b0;
    input_b_ack = 1'b0;
    output_z_stb = 1'b0;
    output_z = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        input_a_ack = 1'b0;
        input_b_ack = 1'b0;
        output_z_stb = 1'b0;
        z_pending = 1'b0;
        a_cnt = 0; b_cnt = 0;
      end else begin
        if (input_a_ack) input_a_ack = 1'b0;
        else if (input_a_stb) begin
          if (a_cnt == 0)
            a_d = (a_dly_f >= 0) ? a_dly_f : $urandom_range(0, 3);
          if (a_cnt >= a_d) begin
            input_a_ack = 1'b1;
            al = input_a;
            a_cnt = 0;
          end else a_cnt++;
        end
        if (input_b_ack) input_b_ack = 1'b0;
        else if (input_b_stb) begin
          if (b_cnt == 0)
            b_d = (b_dly_f >= 0) ? b_dly_f : $urandom_range(0, 3);
          if (b_cnt >= b_d) begin
            input_b_ack = 1'b1;
            zv = fmul(al, input_b);
            z_pending = 1'b1;
            z_cnt = 0;
            z_d = (z_dly_f >= 0) ? z_dly_f : $urandom_range(0, 4);
            b_cnt = 0;
          end else b_cnt++;
        end
        if (output_z_stb && output_z_ack) output_z_stb = 1'b0;
        else if (z_pending && !output_z_stb) begin
          if (z_cnt >= z_d) begin
            output_z = zv;
            output_z_stb = 1'b1;
            z_pending = 1'b0;
          end else z_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_req_ready"}, 64'(req_ready), 0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 0);
    chk({tag, "_a_stb"}, 64'(input_a_stb), 0);
    chk({tag, "_b_stb"}, 64'(input_b_stb), 0);
    chk({tag, "_z_ack"}, 64'(output_z_ack), 0);
    chk({tag, "_input_a"}, 64'(input_a), 0);
    chk({tag, "_input_b"}, 64'(input_b), 0);
    chk({tag, "_resp_z"}, 64'(resp_z), 0);
    chk({tag, "_grant_id"}, 64'(grant_id), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    sb.delete();
    ptr_m = N - 1;
    gnt_seen = '0;
    waiting = '0;
    b_len = 0;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input int n, input string name);
    int c = 0;
    while (done_cnt < n && c < 500) begin
      step();
      c++;
    end
    chk(name, 64'(done_cnt >= n), 1);
  endtask

  task automatic issue(input int ln, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int c = 0;
    gnt_seen[ln] = 1'b0;
    req_a[ln] = a;
    req_b[ln] = b;
    req_valid[ln] = 1'b1;
    while (!gnt_seen[ln] && c < 100) begin
      step();
      c++;
    end
    chk("req_ready_seen", 64'(gnt_seen[ln]), 1);
    if (gnt_seen[ln]) chk("a_stb_latency", 64'(input_a_stb), 1);
    req_valid[ln] = 1'b0;
    gnt_seen[ln] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int c;
    int ord2 [5];
    int ord3 [3];
    logic [W-1:0] zs;
    ord2 = '{0, 1, 2, 3, 0};
    ord3 = '{1, 0, 1};
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = '0;
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single request, 2.0 * 3.0.
    resp_ready = '1;
    d0 = done_cnt;
    issue(0, 32'h40000000, 32'h40400000);
    wait_done(d0 + 1, "t1_done");
    chk("t1_z", 64'(last_z), 64'h40C00000);
    chk("t1_id", 64'(last_id), 0);

    // Stray result strobe while idle is ignored.
    step();
    output_z = 32'hDEADBEEF;
    output_z_stb = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_z_ack", 64'(output_z_ack), 0);
      chk("stray_busy", 64'(busy), 0);
    end
    step();
    output_z_stb = 1'b0;

    // 2: all four held, results consumed at once.
    do_reset("rst2");
    glog.delete();
    resp_ready = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i] = rand_fp();
      req_b[i] = rand_fp();
    end
    d0 = done_cnt;
    req_valid = '1;
    wait_done(d0 + 5, "t2_done");
    req_valid = '0;
    gnt_seen = '0;
    chk("t2_len", 64'(glog.size() >= 5), 1);
    for (int i = 0; i < 5; i++)
      if (i < glog.size()) chk("t2_order", 64'(glog[i]), 64'(ord2[i]));

    // 3: wrap from ptr=1.
    repeat (2) step();
    glog.delete();
    d0 = done_cnt;
    issue(1, rand_fp(), rand_fp());
    wait_done(d0 + 1, "t3_first");
    req_a[0] = rand_fp();
    req_b[0] = rand_fp();
    req_valid = 4'b0011;
    wait_done(d0 + 3, "t3_done");
    req_valid = '0;
    gnt_seen = '0;
    chk("t3_len", 64'(glog.size()), 3);
    for (int i = 0; i < 3; i++)
      if (i < glog.size()) chk("t3_order", 64'(glog[i]), 64'(ord3[i]));

    // 4: slow B accept, others requesting meanwhile.
    repeat (2) step();
    glog.delete();
    b_dly_f = 5;
    d0 = done_cnt;
    issue(1, rand_fp(), rand_fp());
    for (int i = 0; i < N; i++) begin
      req_a[i] = rand_fp();
      req_b[i] = rand_fp();
    end
    req_valid = 4'b1101;
    wait_done(d0 + 1, "t4_done");
    req_valid = '0;
    gnt_seen = '0;
    b_dly_f = -1;
    chk("t4_b_stb_len", 64'(last_b_len), 6);
    chk("t4_grants", 64'(glog.size()), 1);

    // 5: result held while lane 2 stalls.
    repeat (2) step();
    glog.delete();
    resp_ready = '0;
    d0 = done_cnt;
    issue(2, rand_fp(), rand_fp());
    c = 0;
    while (!resp_valid[2] && c < 100) begin
      step();
      c++;
    end
    chk("t5_resp_seen", 64'(resp_valid[2]), 1);
    zs = resp_z;
    req_valid = 4'b1011;
    resp_ready = 4'b1011;
    repeat (10) begin
      @(negedge clk);
      chk("t5_resp_valid", 64'(resp_valid), 64'h4);
      chk("t5_resp_z", 64'(resp_z), 64'(zs));
      chk("t5_busy", 64'(busy), 1);
      chk("t5_no_grant", 64'(req_ready), 0);
    end
    step();
    req_valid = '0;
    resp_ready = '1;
    wait_done(d0 + 1, "t5_done");
    gnt_seen = '0;
    chk("t5_grants", 64'(glog.size()), 1);

    // 6: reset while waiting for the product.
    repeat (2) step();
    z_dly_f = 40;
    issue(1, rand_fp(), rand_fp());
    c = 0;
    while (!(z_pending && !input_b_stb && busy) && c < 100) begin
      step();
      c++;
    end
    chk("t6_in_wait_z", 64'(z_pending && busy), 1);
    do_reset("rst6");
    z_dly_f = -1;
    glog.delete();
    d0 = done_cnt;
    issue(3, 32'h3F800000, 32'h42B1CCCD);
    wait_done(d0 + 1, "t6_done");
    chk("t6_z", 64'(last_z), 64'h42B1CCCD);
    chk("t6_id", 64'(last_id), 3);
    chk("t6_first_grant", 64'(glog.size() > 0 ? glog[0] : -1), 3);

    // Random traffic.
    gnt_seen = '0;
    d0 = done_cnt;
    c = 0;
    while (done_cnt < d0 + 150 && c < 20000) begin
      step();
      c++;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && gnt_seen[i]) begin
          req_valid[i] = 1'b0;
          gnt_seen[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
          else if ($urandom_range(0, 9) == 0) begin
            req_a[i] = rand_fp();
            req_b[i] = rand_fp();
          end
        end else if (!waiting[i] && $urandom_range(0, 2) == 0) begin
          req_a[i] = rand_fp();
          req_b[i] = rand_fp();
          req_valid[i] = 1'b1;
        end
        resp_ready[i] = 1'($urandom_range(0, 1));
      end
    end
    chk("rand_progress", 64'(done_cnt >= d0 + 150), 1);
    req_valid = '0;
    resp_ready = '1;
    c = 0;
    while ((busy || sb.size() != 0) && c < 200) begin
      step();
      c++;
    end
    chk("rand_drain", 64'(busy || sb.size() != 0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
